// File: rtl/combination_pkg.sv
// -----------------------------------------------------------------------------
// combination_pkg
// Shared definitions for the COO combination engine:
//   - state_e   : FSM state encoding (3-bit)
//   - row_elem  : extracts element c (width w) from a packed product row
// No ports (package).
// -----------------------------------------------------------------------------
package combination_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_EDGE_SRC = 3'd2,
    S_EDGE_DST = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  // Widest packed row the element helper accepts; callers zero-extend into it.
  localparam int ROW_MAX_W = 256;

  // Element c of a packed row whose elements are w bits wide (w <= 32).
  function automatic logic [31:0] row_elem(input logic [ROW_MAX_W-1:0] row,
                                           input int unsigned c,
                                           input int unsigned w);
    logic [ROW_MAX_W-1:0] v_sh;
    v_sh = row >> (c * w);
    // For w == 32 the shift wraps to 0 and the mask becomes all ones.
    return v_sh[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/combination_coo_engine_if.sv
// -----------------------------------------------------------------------------
// combination_coo_engine_if
// Bundles the engine's control, COO-memory, product-buffer and readback
// signals.  clk/reset are plain ports on the modules.
//   master : the engine (drives addresses, status and readback data)
//   slave  : the environment (drives start, memory data, readback address)
// -----------------------------------------------------------------------------
interface combination_coo_engine_if #(
  parameter int FEATURE_ROWS = 6,
  parameter int WEIGHT_COLS  = 3,
  parameter int NUM_EDGES    = 6,
  parameter int PROD_W       = 16,
  parameter int ACC_W        = 20,
  parameter int NODE_W       = $clog2(FEATURE_ROWS),
  parameter int EDGE_W       = $clog2(NUM_EDGES)
);
  logic                           start;
  logic [EDGE_W-1:0]              coo_address;
  logic [NODE_W-1:0]              coo_src;
  logic [NODE_W-1:0]              coo_dst;
  logic [NODE_W-1:0]              read_row;
  logic [WEIGHT_COLS*PROD_W-1:0]  fm_wm_row_in;
  logic [NODE_W-1:0]              out_row_addr;
  logic [WEIGHT_COLS*ACC_W-1:0]   out_row_data;
  logic                           busy;
  logic                           done;
  logic                           error;

  modport master (
    input  start, coo_src, coo_dst, fm_wm_row_in, out_row_addr,
    output coo_address, read_row, out_row_data, busy, done, error
  );

  modport slave (
    output start, coo_src, coo_dst, fm_wm_row_in, out_row_addr,
    input  coo_address, read_row, out_row_data, busy, done, error
  );
endinterface

// File: rtl/combination_acc_bank.sv
// -----------------------------------------------------------------------------
// combination_acc_bank
// FEATURE_ROWS x WEIGHT_COLS x ACC_W accumulator register file.
// Ports:
//   clk, reset   : clock, async active-high clear to 0
//   i_wr_en      : write strobe
//   i_wr_add     : 1 = accumulate (acc += row), 0 = overwrite (acc = row)
//   i_wr_addr    : row written (out-of-range addresses are ignored)
//   i_wr_row     : packed product row, zero-extended per element
//   i_rd_addr    : combinational read address (out of range reads 0)
//   o_rd_row     : packed accumulator row
// -----------------------------------------------------------------------------
module combination_acc_bank
  import combination_pkg::*;
#(
  parameter int FEATURE_ROWS = 6,
  parameter int WEIGHT_COLS  = 3,
  parameter int PROD_W       = 16,
  parameter int ACC_W        = 20,
  parameter int NODE_W       = $clog2(FEATURE_ROWS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_wr_en,
  input  logic                          i_wr_add,
  input  logic [NODE_W-1:0]             i_wr_addr,
  input  logic [WEIGHT_COLS*PROD_W-1:0] i_wr_row,
  input  logic [NODE_W-1:0]             i_rd_addr,
  output logic [WEIGHT_COLS*ACC_W-1:0]  o_rd_row
);

  logic [ACC_W-1:0] r_acc  [FEATURE_ROWS][WEIGHT_COLS];
  logic [ACC_W-1:0] w_elem [WEIGHT_COLS];
  logic             w_wr_in_range;
  logic             w_rd_in_range;

  assign w_wr_in_range = (32'(i_wr_addr) < FEATURE_ROWS);
  assign w_rd_in_range = (32'(i_rd_addr) < FEATURE_ROWS);

  // Split the incoming product row into zero-extended elements.
  always_comb begin
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      w_elem[c] = ACC_W'(row_elem(ROW_MAX_W'(i_wr_row), c, PROD_W));
    end
  end

  // Accumulator storage: overwrite or modulo-2^ACC_W accumulate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FEATURE_ROWS; i++) begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          r_acc[i][c] <= '0;
        end
      end
    end else if (i_wr_en && w_wr_in_range) begin
      for (int c = 0; c < WEIGHT_COLS; c++) begin
        r_acc[i_wr_addr][c] <= i_wr_add ? (r_acc[i_wr_addr][c] + w_elem[c]) : w_elem[c];
      end
    end
  end

  // Combinational readback port.
  always_comb begin
    o_rd_row = '0;
    if (w_rd_in_range) begin
      for (int c = 0; c < WEIGHT_COLS; c++) begin
        o_rd_row[c*ACC_W +: ACC_W] = r_acc[i_rd_addr][c];
      end
    end else begin
      o_rd_row = '0;
    end
  end

endmodule

// File: rtl/combination_coo_engine.sv
// -----------------------------------------------------------------------------
// combination_coo_engine
// Aggregates the FM x WM product buffer over a COO edge list into a per-node
// accumulator bank (A_hat * (F * W), self-loops included).
// Ports:
//   clk, reset : clock, async active-high reset
//   bus        : combination_coo_engine_if.master
//                start / coo_address / coo_src / coo_dst / read_row /
//                fm_wm_row_in / out_row_addr / out_row_data / busy / done / error
// Edge fields are fetched one cycle ahead: coo_address points at the next
// edge while the current one is processed, so that read_row can be a
// register and still carry the current edge's source in EDGE_SRC.
// -----------------------------------------------------------------------------
module combination_coo_engine
  import combination_pkg::*;
#(
  parameter int FEATURE_ROWS = 6,
  parameter int WEIGHT_COLS  = 3,
  parameter int NUM_EDGES    = 6,
  parameter int PROD_W       = 16,
  parameter int ACC_W        = 20,
  parameter int NODE_W       = $clog2(FEATURE_ROWS),
  parameter int EDGE_W       = $clog2(NUM_EDGES)
) (
  input logic                      clk,
  input logic                      reset,
  combination_coo_engine_if.master bus
);

  localparam logic [2:0] ST_IDLE     = S_IDLE;
  localparam logic [2:0] ST_INIT     = S_INIT;
  localparam logic [2:0] ST_EDGE_SRC = S_EDGE_SRC;
  localparam logic [2:0] ST_EDGE_DST = S_EDGE_DST;
  localparam logic [2:0] ST_DONE     = S_DONE;

  localparam logic [NODE_W-1:0] LAST_ROW  = NODE_W'(FEATURE_ROWS - 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(NUM_EDGES - 1);

  logic [2:0]        r_state;
  logic [NODE_W-1:0] r_row;
  logic [EDGE_W-1:0] r_edge;
  logic [EDGE_W-1:0] r_coo_address;
  logic [NODE_W-1:0] r_read_row;
  logic [NODE_W-1:0] r_src;
  logic [NODE_W-1:0] r_dst;
  logic              r_error;

  logic              w_edge_ok;
  logic              w_self;
  logic              w_advance;
  logic [EDGE_W-1:0] w_next_fetch;
  logic              w_wr_en;
  logic              w_wr_add;
  logic [NODE_W-1:0] w_wr_addr;

  assign w_edge_ok    = (32'(r_src) < FEATURE_ROWS) && (32'(r_dst) < FEATURE_ROWS);
  assign w_self       = (r_src == r_dst);
  // One-cycle edges (self-loop or invalid) leave straight from EDGE_SRC.
  assign w_advance    = ((r_state == ST_EDGE_SRC) && !(w_edge_ok && !w_self)) ||
                        (r_state == ST_EDGE_DST);
  assign w_next_fetch = (r_coo_address == LAST_EDGE) ? r_coo_address
                                                     : r_coo_address + EDGE_W'(1);

  assign bus.coo_address = r_coo_address;
  assign bus.read_row    = r_read_row;
  assign bus.busy        = (r_state == ST_INIT) || (r_state == ST_EDGE_SRC) ||
                           (r_state == ST_EDGE_DST);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.error       = r_error;

  // Accumulator write-port control per state.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_add  = 1'b0;
    w_wr_addr = r_row;
    case (r_state)
      ST_INIT: begin
        w_wr_en   = 1'b1;
        w_wr_add  = 1'b0;
        w_wr_addr = r_row;
      end
      ST_EDGE_SRC: begin
        w_wr_en   = w_edge_ok;
        w_wr_add  = 1'b1;
        w_wr_addr = r_dst;
      end
      ST_EDGE_DST: begin
        w_wr_en   = 1'b1;
        w_wr_add  = 1'b1;
        w_wr_addr = r_src;
      end
      default: begin
        w_wr_en   = 1'b0;
        w_wr_add  = 1'b0;
        w_wr_addr = r_row;
      end
    endcase
  end

  // FSM, row/edge counters, edge prefetch and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_row         <= '0;
      r_edge        <= '0;
      r_coo_address <= '0;
      r_read_row    <= '0;
      r_src         <= '0;
      r_dst         <= '0;
      r_error       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state       <= ST_INIT;
            r_row         <= '0;
            r_read_row    <= '0;
            r_coo_address <= '0;
            r_error       <= 1'b0;
          end
        end
        ST_INIT: begin
          if (r_row == LAST_ROW) begin
            // coo_address is 0 here: latch edge 0 and prefetch edge 1.
            r_state       <= ST_EDGE_SRC;
            r_edge        <= '0;
            r_src         <= bus.coo_src;
            r_dst         <= bus.coo_dst;
            r_read_row    <= bus.coo_src;
            r_coo_address <= w_next_fetch;
          end else begin
            r_row      <= r_row + NODE_W'(1);
            r_read_row <= r_row + NODE_W'(1);
          end
        end
        ST_EDGE_SRC: begin
          if (!w_edge_ok) begin
            r_error <= 1'b1;
          end
          if (w_edge_ok && !w_self) begin
            r_state    <= ST_EDGE_DST;
            r_read_row <= r_dst;
          end
        end
        ST_EDGE_DST: begin
          r_state <= ST_EDGE_DST;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      if (w_advance) begin
        if (r_edge == LAST_EDGE) begin
          r_state <= ST_DONE;
        end else begin
          r_state       <= ST_EDGE_SRC;
          r_edge        <= r_edge + EDGE_W'(1);
          r_src         <= bus.coo_src;
          r_dst         <= bus.coo_dst;
          r_read_row    <= bus.coo_src;
          r_coo_address <= w_next_fetch;
        end
      end
    end
  end

  combination_acc_bank #(
    .FEATURE_ROWS (FEATURE_ROWS),
    .WEIGHT_COLS  (WEIGHT_COLS),
    .PROD_W       (PROD_W),
    .ACC_W        (ACC_W),
    .NODE_W       (NODE_W)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_add  (w_wr_add),
    .i_wr_addr (w_wr_addr),
    .i_wr_row  (bus.fm_wm_row_in),
    .i_rd_addr (bus.out_row_addr),
    .o_rd_row  (bus.out_row_data)
  );

endmodule

// File: tb/tb_combination_coo_engine.sv
// -----------------------------------------------------------------------------
// tb_combination_coo_engine
// Scoreboard bench: stimulus pushes hand-computed expectations into a queue,
// monitors pop and compare when the engine raises done (or, for reset
// records, on the next cycle).  Product row i = {i+1, i+1, i+1}.
// A second engine with ACC_W=16 checks modulo wrap on all-0xFFFF rows.
// -----------------------------------------------------------------------------
module tb_combination_coo_engine;

  typedef struct packed {
    logic             is_reset;
    logic             err;
    logic [7:0]       cycles;
    logic [5:0][59:0] rows;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   t_start = 0;
  int   checks = 0;
  int   errors = 0;
  int   handled = 0;
  int   handled16 = 0;
  int   n_expect = 0;

  exp_t        q[$];
  logic [47:0] q16[$];

  logic [2:0] src_mem [6];
  logic [2:0] dst_mem [6];

  combination_coo_engine_if bus ();
  combination_coo_engine_if #(.ACC_W(16)) bus16 ();

  combination_coo_engine u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  combination_coo_engine #(.ACC_W(16)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // COO memory and product buffer models for the default engine.
  always_comb begin
    bus.coo_src      = (bus.coo_address < 3'd6) ? src_mem[bus.coo_address] : 3'd0;
    bus.coo_dst      = (bus.coo_address < 3'd6) ? dst_mem[bus.coo_address] : 3'd0;
    bus.fm_wm_row_in = (bus.read_row < 3'd6) ? {3{16'(bus.read_row) + 16'd1}} : 48'd0;
  end

  // Wrap engine: every edge is (0,1), every row is all 0xFFFF.
  always_comb begin
    bus16.coo_src      = 3'd0;
    bus16.coo_dst      = 3'd1;
    bus16.fm_wm_row_in = {3{16'hFFFF}};
    bus16.out_row_addr = 3'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_run(input int a0, input int a1, input int a2, input int a3,
                                  input int a4, input int a5, input int lat, input logic err);
    exp_t e;
    e.is_reset = 1'b0;
    e.err      = err;
    e.cycles   = 8'(lat);
    e.rows[0]  = {3{20'(a0)}};
    e.rows[1]  = {3{20'(a1)}};
    e.rows[2]  = {3{20'(a2)}};
    e.rows[3]  = {3{20'(a3)}};
    e.rows[4]  = {3{20'(a4)}};
    e.rows[5]  = {3{20'(a5)}};
    return e;
  endfunction

  function automatic exp_t mk_reset();
    exp_t e;
    e = '0;
    e.is_reset = 1'b1;
    return e;
  endfunction

  // Monitor for the default engine: fires on done rising or on a queued reset record.
  initial begin : monitor
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    bus.out_row_addr = 3'd0;
    forever begin
      @(posedge clk);
      #1;
      if ((q.size() > 0 && q[0].is_reset) || (bus.done && !prev_done)) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no pending pass");
        end else begin
          e = q.pop_front();
          if (e.is_reset) begin
            check("rst_busy", 64'(bus.busy), 64'd0);
            check("rst_done", 64'(bus.done), 64'd0);
            check("rst_error", 64'(bus.error), 64'd0);
            check("rst_coo_address", 64'(bus.coo_address), 64'd0);
            check("rst_read_row", 64'(bus.read_row), 64'd0);
          end else begin
            check("latency", 64'(cyc - t_start), 64'(e.cycles));
            check("error", 64'(bus.error), 64'(e.err));
            check("busy_at_done", 64'(bus.busy), 64'd0);
          end
          for (int i = 0; i < 6; i++) begin
            bus.out_row_addr = 3'(i);
            #1;
            check($sformatf("acc_row%0d", i), 64'(bus.out_row_data), 64'(e.rows[i]));
          end
          bus.out_row_addr = 3'd0;
        end
        handled++;
      end
      prev_done = bus.done;
    end
  end

  // Monitor for the ACC_W=16 engine: checks the wrapped row 1 and latency.
  initial begin : monitor16
    logic prev_done;
    logic [47:0] e;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus16.done && !prev_done) begin
        if (q16.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done16: got done=1, expected no pending pass");
        end else begin
          e = q16.pop_front();
          check("wrap_row1", 64'(bus16.out_row_data), 64'(e));
          check("wrap_latency", 64'(cyc - t_start), 64'd19);
        end
        handled16++;
      end
      prev_done = bus16.done;
    end
  end

  task automatic wait_handled();
    int n;
    n = 0;
    while ((handled + handled16) < n_expect && n < 300) begin
      @(posedge clk);
      n++;
    end
    if ((handled + handled16) < n_expect) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d handled, expected %0d", handled + handled16, n_expect);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
    @(negedge clk);
  endtask

  task automatic set_edges(input logic [2:0] s, input logic [2:0] d);
    for (int i = 0; i < 6; i++) begin
      src_mem[i] = s;
      dst_mem[i] = d;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_pass(input exp_t e, input bit glitch);
    q.push_back(e);
    n_expect++;
    pulse_start();
    if (glitch) begin
      // start during INIT must be ignored
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_handled();
  endtask

  initial begin : stimulus
    bus.start   = 1'b0;
    bus16.start = 1'b0;
    set_edges(3'd0, 3'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    q.push_back(mk_reset());
    n_expect++;
    wait_handled();

    // All six edges (0,1), with a start pulse while busy.
    run_pass(mk_run(13, 8, 3, 4, 5, 6, 19, 1'b0), 1'b1);

    // Edge 2 invalid (7,0): one-cycle edge, error set.
    set_edges(3'd0, 3'd1);
    src_mem[2] = 3'd7;
    dst_mem[2] = 3'd0;
    run_pass(mk_run(11, 7, 3, 4, 5, 6, 18, 1'b1), 1'b0);

    // All self-loops (3,3); start from DONE must clear error.
    set_edges(3'd3, 3'd3);
    run_pass(mk_run(1, 2, 3, 28, 5, 6, 13, 1'b0), 1'b0);

    // Reset while in EDGE_DST (state after the 8th edge since start).
    set_edges(3'd0, 3'd1);
    pulse_start();
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.push_back(mk_reset());
    n_expect++;
    wait_handled();

    // Clean run after reset, then an identical run straight from DONE.
    run_pass(mk_run(13, 8, 3, 4, 5, 6, 19, 1'b0), 1'b0);
    run_pass(mk_run(13, 8, 3, 4, 5, 6, 19, 1'b0), 1'b0);

    // ACC_W=16 wrap: 7 * 0xFFFF mod 2^16 = 0xFFF9.
    q16.push_back({3{16'hFFF9}});
    n_expect++;
    @(negedge clk);
    bus16.start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    bus16.start = 1'b0;
    wait_handled();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/combination_coo_engine.md
# combination_coo_engine

Downstream neighbour of the transformation stage in the GCN layer. Once the FM×WM product buffer is complete, this block aggregates it over the graph: it walks a COO edge list and accumulates product rows into a per-node accumulator bank. The bank holds the combination result (Â·(F·W), self-loops included), which the next stage reads back.

## Interface
Parameters:
- FEATURE_ROWS, 6, number of graph nodes (rows of the product buffer)
- WEIGHT_COLS, 3, elements per product row
- NUM_EDGES, 6, entries in the COO memory
- PROD_W, 16, width of one product element (unsigned)
- ACC_W, 20, width of one accumulator element
- NODE_W, $clog2(FEATURE_ROWS), node index width (derived)
- EDGE_W, $clog2(NUM_EDGES), COO address width (derived)

Ports:
- clk  in  1  single clock; everything is on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin a pass; sampled in IDLE and DONE only
- coo_address  out  EDGE_W  COO memory read address (registered)
- coo_src  in  NODE_W  source node of the addressed edge (combinational read)
- coo_dst  in  NODE_W  destination node of the addressed edge
- read_row  out  NODE_W  product buffer row address (registered)
- fm_wm_row_in  in  WEIGHT_COLS*PROD_W  product row at read_row; element c at bits [c*PROD_W +: PROD_W]
- out_row_addr  in  NODE_W  accumulator readback address
- out_row_data  out  WEIGHT_COLS*ACC_W  combinational read of accumulator row out_row_addr
- busy  out  1  high in INIT and EDGE states
- done  out  1  high while in DONE
- error  out  1  sticky flag: an edge had a node index ≥ FEATURE_ROWS; cleared by reset or a new start

## Operation
- States: IDLE, INIT, EDGE_SRC, EDGE_DST, DONE.
- IDLE: on start, go to INIT with row counter r=0 and error cleared.
- INIT: drive read_row=r and write acc[r] ← zero-extended fm_wm_row_in (overwrite). At r=FEATURE_ROWS-1, go to EDGE_SRC with e=0. Otherwise r++.
- EDGE_SRC:
  - drive coo_address=e and read_row=coo_src; add acc[coo_dst] += row.
  - If coo_src==coo_dst, skip EDGE_DST and advance the edge.
- EDGE_DST: drive read_row=coo_dst; add acc[coo_src] += row, then advance the edge.
- Advance edge: if e==NUM_EDGES-1, go to DONE; otherwise e++ and go to EDGE_SRC.
- Invalid edge: if coo_src or coo_dst ≥ FEATURE_ROWS, no accumulator write occurs, error is set, and the edge takes one EDGE_SRC cycle only.
- DONE: done=1, state is held. start re-enters INIT; INIT overwrites, so a re-run does not double-accumulate.
- Arithmetic: unsigned, per element, modulo 2^ACC_W (wraps, no saturation).

## Timing
- Reset values: state=IDLE, all accumulators 0, coo_address=0, read_row=0, busy=0, done=0, error=0.
- start sampled at edge k. INIT occupies cycles k+1 … k+FEATURE_ROWS. Each valid non-self edge takes 2 cycles; a self-loop or invalid edge takes 1.
- done rises one cycle after the last edge cycle. With defaults and all edges valid and distinct: start → done = 1+6+12 = 19 cycles.
- out_row_data reflects an accumulator write on the cycle after that write.
- start while busy is ignored.
- Reset mid-pass returns to IDLE immediately and clears the bank.

## Structure
- combination_pkg:
  - state enum (3-bit)
  - helper to extract element c of a packed row
- Sub-module combination_acc_bank:
  - FEATURE_ROWS×WEIGHT_COLS×ACC_W register file
  - one write port with add/overwrite select
  - one combinational read port
  - async reset to 0
- The top level holds the FSM and the r/e counters.

## Test plan
Common setup for all scenarios: defaults, with product row i = {i+1, i+1, i+1}.
- All six edges (0,1) → acc0 = 13, acc1 = 8, acc2..5 = 3..6; done 19 cycles after start; error=0.
- All edges (3,3) self-loop → acc3 = 28, others own row; done 13 cycles after start.
- Edge 2 = (7,0), remaining edges (0,1) → error=1; acc0 = 11, acc1 = 7; the invalid edge takes 1 cycle.
- Reset asserted during EDGE_DST, then released → all outputs and out_row_data = 0, state IDLE; a new start gives the same result as a clean run.
- Two consecutive starts from DONE with identical inputs → identical bank contents, no doubling.
- ACC_W=16, rows all 0xFFFF, edge (0,1) ×6 → acc1 element = (7·0xFFFF) mod 2^16 = 0xFFF9.
